serial_divisibility_controller: RTL

- Accepts a W-bit word on a valid/ready handshake and serializes it MSB-first, one bit per clock.
- Feeds the bit stream to internal remainder state machines for divisors 3 and 5, and mirrors the same stream on a serial port so external serial_divisibility_by_3/5 FSMs can be driven in lockstep.
- Reports the final divisibility flags and remainders on an output valid/ready handshake.
- Sits between a word-oriented producer and the bit-serial divisibility datapath, sequencing its use.

---
 rtl/serial_divisibility_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_divisibility_controller.sv
// rtl/serial_divisibility_controller.sv - word-to-bit-serial divisibility-by-3/5 controller (optional SERIAL_DIV_BACK_TO_BACK_EN)
module serial_divisibility_controller #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         ser_valid,
  output logic         ser_bit,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_div_by_3,
  output logic         out_div_by_5,
  output logic [1:0]   out_rem3,
  output logic [2:0]   out_rem5
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rem3_q, rem3_d;
  logic [2:0]    rem5_q, rem5_d;

  // (2*r + b) mod 3 as a lookup on the 3-bit {r, b}
  function automatic logic [1:0] rem3_step(input logic [1:0] r, input logic b);
    logic [1:0] n;
    case ({r, b})
      3'b000:  n = 2'd0;
      3'b001:  n = 2'd1;
      3'b010:  n = 2'd2;
      3'b011:  n = 2'd0;
      3'b100:  n = 2'd1;
      3'b101:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // (2*r + b) mod 5 by one compare-subtract on the 4-bit {r, b}
  function automatic logic [2:0] rem5_step(input logic [2:0] r, input logic b);
    logic [3:0] t;
    t = {r, b};
    if (t >= 4'd5) begin
      t = t - 4'd5;
    end
    return t[2:0];
  endfunction

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      rem3_q  <= 2'd0;
      rem5_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      rem3_q  <= rem3_d;
      rem5_q  <= rem5_d;
    end
  end

  // Next-state, datapath updates and handshake outputs
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    rem3_d    = rem3_q;
    rem5_d    = rem5_q;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d = in_data;
          cnt_d   = CNT_LOAD;
          rem3_d  = 2'd0;
          rem5_d  = 3'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ser_valid = 1'b1;
        rem3_d    = rem3_step(rem3_q, shift_q[W-1]);
        rem5_d    = rem5_step(rem5_q, shift_q[W-1]);
        shift_d   = {shift_q[W-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
`ifdef SERIAL_DIV_BACK_TO_BACK_EN
        // Consuming the result frees the datapath, so a waiting word can load on the same edge
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            shift_d = in_data;
            cnt_d   = CNT_LOAD;
            rem3_d  = 2'd0;
            rem5_d  = 3'd0;
            state_d = S_SHIFT;
          end else begin
            state_d = S_IDLE;
          end
        end
`else
        if (out_ready) begin
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ser_bit      = shift_q[W-1];
  assign busy         = (state_q != S_IDLE);
  assign out_rem3     = rem3_q;
  assign out_rem5     = rem5_q;
  assign out_div_by_3 = (rem3_q == 2'd0);
  assign out_div_by_5 = (rem5_q == 3'd0);

endmodule
